// File: rtl/lsu_mem_stage_pkg.sv
// lsu_mem_stage_pkg: memory-op codes, bus typedefs and FSM encoding shared by the MEM stage.
`default_nettype none

package lsu_mem_stage_pkg;

    localparam int MEM_OP_W = 4;

    typedef logic [MEM_OP_W-1:0] mem_op_t;
    typedef logic [31:0]         reg_bus_t;
    typedef logic [4:0]          reg_addr_t;

    localparam reg_bus_t ZERO_WORD = 32'h0000_0000;

    localparam mem_op_t OP_NONE = 4'd0;
    localparam mem_op_t OP_LB   = 4'd1;
    localparam mem_op_t OP_LH   = 4'd2;
    localparam mem_op_t OP_LW   = 4'd3;
    localparam mem_op_t OP_LBU  = 4'd4;
    localparam mem_op_t OP_LHU  = 4'd5;
    localparam mem_op_t OP_SB   = 4'd6;
    localparam mem_op_t OP_SH   = 4'd7;
    localparam mem_op_t OP_SW   = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } lsu_state_t;

    function automatic logic is_load(input mem_op_t op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lo[0];
            OP_LW, OP_SW:         return lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: req/ack data-bus bundle between the MEM stage (master) and memory (slave).
`default_nettype none

interface lsu_mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, sel, wdata, input ack, rdata);
    modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
// lsu_align: byte-lane select / store replication for the outgoing request and
// extract/extend of the returning load word (purely combinational).
`default_nettype none

module lsu_align
    import lsu_mem_stage_pkg::*;
(
    input  mem_op_t    req_op,
    input  logic [1:0] req_lo,
    input  reg_bus_t   sdata,
    output logic [3:0] sel,
    output reg_bus_t   wdata,
    input  mem_op_t    ld_op,
    input  logic [1:0] ld_lo,
    input  reg_bus_t   rdata,
    output reg_bus_t   ldata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        sel   = 4'b0000;
        wdata = sdata;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: begin
                sel   = 4'b0001 << req_lo;
                wdata = {4{sdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                sel   = req_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{sdata[15:0]}};
            end
            OP_LW, OP_SW: sel = 4'b1111;
            default:      sel = 4'b0000;
        endcase
    end

    always_comb begin
        case (ld_lo)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_lo[1] ? rdata[31:16] : rdata[15:0];

        case (ld_op)
            OP_LB:   ldata = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ldata = {24'h000000, ld_byte};
            OP_LH:   ldata = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ldata = {16'h0000, ld_half};
            OP_LW:   ldata = rdata;
            default: ldata = ZERO_WORD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32I MEM stage -- issues loads/stores on a req/ack bus and drives the
// regfile write port. Optional bus watchdog enabled by macro LSU_TIMEOUT_EN.
`default_nettype none

module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int OP_W           = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            in_valid_i,
    input  wire logic            wreg_i,
    input  wire logic [4:0]      wd_i,
    input  wire logic [31:0]     wdata_i,
    input  wire logic [OP_W-1:0] mem_op_i,
    input  wire logic [31:0]     sdata_i,
    lsu_mem_stage_if.master      mem,
    output logic                 wb_we_o,
    output logic [4:0]           wb_waddr_o,
    output logic [31:0]          wb_wdata_o,
    output logic                 stall_req_o,
    output logic                 misalign_o
`ifdef LSU_TIMEOUT_EN
    ,
    output logic                 bus_err_o
`endif
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    lsu_state_t  state;
    mem_op_t     op;
    mem_op_t     ld_op;
    logic [1:0]  ld_lo;
    reg_addr_t   ld_wd;
    logic [31:0] op_wide;
    logic        op_is_mem;
    logic        op_misal;
    logic [3:0]  req_sel;
    reg_bus_t    req_wdata;
    reg_bus_t    ld_data;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_cnt;
`endif

    // Codes above SW (including wider-than-4-bit encodings) collapse to NONE.
    assign op_wide   = 32'(mem_op_i);
    assign op        = (op_wide <= 32'd8) ? op_wide[3:0] : OP_NONE;
    assign op_is_mem = is_load(op) || is_store(op);
    assign op_misal  = is_misaligned(op, wdata_i[1:0]);

    assign stall_req_o = ((state == ST_IDLE) && in_valid_i && op_is_mem && !op_misal) ||
                         ((state == ST_BUS) && !mem.ack);

    lsu_align u_align (
        .req_op (op),
        .req_lo (wdata_i[1:0]),
        .sdata  (sdata_i),
        .sel    (req_sel),
        .wdata  (req_wdata),
        .ld_op  (ld_op),
        .ld_lo  (ld_lo),
        .rdata  (mem.rdata),
        .ldata  (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mem.req    <= 1'b0;
            mem.we     <= 1'b0;
            mem.addr   <= ZERO_WORD;
            mem.sel    <= 4'b0000;
            mem.wdata  <= ZERO_WORD;
            ld_op      <= OP_NONE;
            ld_lo      <= 2'b00;
            ld_wd      <= 5'd0;
            wb_we_o    <= 1'b0;
            wb_waddr_o <= 5'd0;
            wb_wdata_o <= ZERO_WORD;
            misalign_o <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt    <= '0;
            bus_err_o  <= 1'b0;
`endif
        end else begin
            misalign_o <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            bus_err_o  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (in_valid_i && op_is_mem) begin
                        wb_we_o <= 1'b0;
                        if (op_misal) begin
                            misalign_o <= 1'b1;
                        end else begin
                            state     <= ST_BUS;
                            mem.req   <= 1'b1;
                            mem.we    <= is_store(op);
                            mem.addr  <= {wdata_i[31:2], 2'b00};
                            mem.sel   <= req_sel;
                            mem.wdata <= req_wdata;
                            ld_op     <= op;
                            ld_lo     <= wdata_i[1:0];
                            ld_wd     <= wd_i;
`ifdef LSU_TIMEOUT_EN
                            tmo_cnt   <= '0;
`endif
                        end
                    end else begin
                        wb_we_o    <= in_valid_i && wreg_i && (wd_i != 5'd0);
                        wb_waddr_o <= wd_i;
                        wb_wdata_o <= wdata_i;
                    end
                end

                ST_BUS: begin
                    wb_we_o <= 1'b0;
                    if (mem.ack) begin
                        state   <= ST_IDLE;
                        mem.req <= 1'b0;
                        if (is_load(ld_op)) begin
                            wb_we_o    <= (ld_wd != 5'd0);
                            wb_waddr_o <= ld_wd;
                            wb_wdata_o <= ld_data;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= ST_IDLE;
                        mem.req   <= 1'b0;
                        bus_err_o <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
`endif
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed bench with a writeback scoreboard for lsu_mem_stage.
`default_nettype none

module tb_lsu_mem_stage;
    import lsu_mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, wreg;
    logic [4:0]  wd;
    logic [31:0] wdata, sdata;
    logic [3:0]  mem_op;
    logic        wb_we, stall, misalign;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
`ifdef LSU_TIMEOUT_EN
    logic        bus_err;
`endif

    int          n_cmp = 0;
    int          n_mis = 0;
    int          stall_hi;
    logic [36:0] exp_q[$];
    logic [36:0] sb_e;

    lsu_mem_stage_if bus ();

    lsu_mem_stage #(.TIMEOUT_CYCLES(16), .OP_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .wreg_i      (wreg),
        .wd_i        (wd),
        .wdata_i     (wdata),
        .mem_op_i    (mem_op),
        .sdata_i     (sdata),
        .mem         (bus),
        .wb_we_o     (wb_we),
        .wb_waddr_o  (wb_waddr),
        .wb_wdata_o  (wb_wdata),
        .stall_req_o (stall),
        .misalign_o  (misalign)
`ifdef LSU_TIMEOUT_EN
        ,
        .bus_err_o   (bus_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] d, input logic [31:0] a,
                         input logic [3:0] op, input logic [31:0] sd);
        in_valid = 1'b1;
        wreg     = w;
        wd       = d;
        wdata    = a;
        mem_op   = op;
        sdata    = sd;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        mem_op   = OP_NONE;
    endtask

    // Every regfile write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_we === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_mis++;
                $error("FAIL wb_unexpected: observed waddr=%0d wdata=0x%08h expected=no write",
                       wb_waddr, wb_wdata);
            end
            if (exp_q.size() > 0) begin
                sb_e = exp_q.pop_front();
                chk("sb_waddr", 32'(wb_waddr), 32'(sb_e[36:32]));
                chk("sb_wdata", wb_wdata, sb_e[31:0]);
            end
        end
    end

    initial begin
        in_valid  = 1'b0;
        wreg      = 1'b0;
        wd        = 5'd0;
        wdata     = 32'h0;
        sdata     = 32'h0;
        mem_op    = OP_NONE;
        bus.ack   = 1'b0;
        bus.rdata = 32'h0;
        tick();
        tick();

        chk("rst_req", 32'(bus.req), 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_addr", bus.addr, 32'h0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_mwdata", bus.wdata, 32'h0);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_waddr", 32'(wb_waddr), 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'h0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU result: one-cycle writeback, no stall
        drive(1'b1, 5'd5, 32'h0000_1234, OP_NONE, 32'h0);
        exp_q.push_back({5'd5, 32'h0000_1234});
        #1 chk("alu_stall", 32'(stall), 32'd0);
        tick();
        chk("alu_wb_we", 32'(wb_we), 32'd1);
        chk("alu_wb_waddr", 32'(wb_waddr), 32'd5);
        chk("alu_wb_wdata", wb_wdata, 32'h0000_1234);

        // x0 destination never writes
        drive(1'b1, 5'd0, 32'h0000_FFFF, OP_NONE, 32'h0);
        tick();
        chk("x0_wb_we", 32'(wb_we), 32'd0);

        // reserved op code behaves as NONE
        drive(1'b1, 5'd4, 32'h0000_0055, 4'd12, 32'h0);
        exp_q.push_back({5'd4, 32'h0000_0055});
        #1 chk("op12_stall", 32'(stall), 32'd0);
        tick();
        chk("op12_wb_we", 32'(wb_we), 32'd1);
        chk("op12_req", 32'(bus.req), 32'd0);

        // stray ack in IDLE
        idle();
        bus.ack   = 1'b1;
        bus.rdata = 32'hFFFF_FFFF;
        tick();
        bus.ack = 1'b0;
        chk("idle_ack_req", 32'(bus.req), 32'd0);
        chk("idle_ack_wb_we", 32'(wb_we), 32'd0);

        // LB at byte 3, ack in the fourth BUS cycle
        drive(1'b1, 5'd7, 32'h0000_1003, OP_LB, 32'h0);
        exp_q.push_back({5'd7, 32'hFFFF_FF80});
        stall_hi = 0;
        #1 stall_hi += int'(stall);
        tick();
        idle();
        chk("lb_req", 32'(bus.req), 32'd1);
        chk("lb_we", 32'(bus.we), 32'd0);
        chk("lb_addr", bus.addr, 32'h0000_1000);
        chk("lb_sel", 32'(bus.sel), 32'h8);
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                bus.ack   = 1'b1;
                bus.rdata = 32'h80FF_FFFF;
            end
            #1 stall_hi += int'(stall);
            if (c == 3) chk("lb_addr_hold", bus.addr, 32'h0000_1000);
            tick();
        end
        bus.ack = 1'b0;
        chk("lb_stall_cycles", 32'(stall_hi), 32'd4);
        chk("lb_req_drop", 32'(bus.req), 32'd0);
        chk("lb_wb_wdata", wb_wdata, 32'hFFFF_FF80);

        // LHU upper half, ack in the first BUS cycle
        drive(1'b1, 5'd9, 32'h0000_2002, OP_LHU, 32'h0);
        exp_q.push_back({5'd9, 32'h0000_BEEF});
        tick();
        idle();
        chk("lhu_sel", 32'(bus.sel), 32'hC);
        chk("lhu_addr", bus.addr, 32'h0000_2000);
        bus.ack   = 1'b1;
        bus.rdata = 32'hBEEF_0000;
        #1 chk("lhu_stall_ack", 32'(stall), 32'd0);
        tick();
        bus.ack = 1'b0;
        chk("lhu_wb_we", 32'(wb_we), 32'd1);
        chk("lhu_wb_wdata", wb_wdata, 32'h0000_BEEF);

        // SH upper half
        drive(1'b0, 5'd3, 32'h0000_3002, OP_SH, 32'h0000_ABCD);
        tick();
        idle();
        chk("sh_we", 32'(bus.we), 32'd1);
        chk("sh_sel", 32'(bus.sel), 32'hC);
        chk("sh_wdata", bus.wdata, 32'hABCD_ABCD);
        chk("sh_addr", bus.addr, 32'h0000_3000);
        #1 chk("sh_stall_wait", 32'(stall), 32'd1);
        tick();
        chk("sh_wb_we_wait", 32'(wb_we), 32'd0);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("sh_wb_we", 32'(wb_we), 32'd0);
        chk("sh_req_drop", 32'(bus.req), 32'd0);

        // SB byte 1
        drive(1'b1, 5'd2, 32'h0000_5001, OP_SB, 32'h1234_5678);
        tick();
        idle();
        chk("sb_sel", 32'(bus.sel), 32'h2);
        chk("sb_wdata_lane", bus.wdata, 32'h7878_7878);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("sb_wb_we", 32'(wb_we), 32'd0);

        // LH sign-extends lower half
        drive(1'b1, 5'd6, 32'h0000_6000, OP_LH, 32'h0);
        exp_q.push_back({5'd6, 32'hFFFF_8001});
        tick();
        idle();
        chk("lh_sel", 32'(bus.sel), 32'h3);
        bus.ack   = 1'b1;
        bus.rdata = 32'h1234_8001;
        tick();
        bus.ack = 1'b0;
        chk("lh_wb_wdata", wb_wdata, 32'hFFFF_8001);

        // LBU byte 2 zero-extends
        drive(1'b1, 5'd8, 32'h0000_1002, OP_LBU, 32'h0);
        exp_q.push_back({5'd8, 32'h0000_00A5});
        tick();
        idle();
        chk("lbu_sel", 32'(bus.sel), 32'h4);
        bus.ack   = 1'b1;
        bus.rdata = 32'h00A5_0000;
        tick();
        bus.ack = 1'b0;
        chk("lbu_wb_wdata", wb_wdata, 32'h0000_00A5);

        // LW word pass-through
        drive(1'b1, 5'd10, 32'h0000_7004, OP_LW, 32'h0);
        exp_q.push_back({5'd10, 32'hDEAD_BEEF});
        tick();
        idle();
        chk("lw_sel", 32'(bus.sel), 32'hF);
        chk("lw_addr", bus.addr, 32'h0000_7004);
        bus.ack   = 1'b1;
        bus.rdata = 32'hDEAD_BEEF;
        tick();
        bus.ack = 1'b0;
        chk("lw_wb_wdata", wb_wdata, 32'hDEAD_BEEF);

        // misaligned LW: single pulse, no bus cycle
        drive(1'b1, 5'd11, 32'h0000_4001, OP_LW, 32'h0);
        #1 chk("mis_stall", 32'(stall), 32'd0);
        tick();
        idle();
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_req", 32'(bus.req), 32'd0);
        chk("mis_wb_we", 32'(wb_we), 32'd0);
        tick();
        chk("mis_pulse_end", 32'(misalign), 32'd0);
        chk("mis_req_after", 32'(bus.req), 32'd0);

        // asynchronous reset while a load is outstanding
        drive(1'b1, 5'd13, 32'h0000_8000, OP_LW, 32'h0);
        tick();
        idle();
        chk("rbus_req", 32'(bus.req), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("rbus_req_async", 32'(bus.req), 32'd0);
        chk("rbus_stall", 32'(stall), 32'd0);
        tick();
        tick();
        rst_n     = 1'b1;
        bus.ack   = 1'b1;
        bus.rdata = 32'h1111_1111;
        tick();
        bus.ack = 1'b0;
        tick();
        chk("rbus_wb_we", 32'(wb_we), 32'd0);
        chk("rbus_req_after", 32'(bus.req), 32'd0);

`ifdef LSU_TIMEOUT_EN
        // unanswered request aborts after TIMEOUT_CYCLES BUS cycles
        drive(1'b1, 5'd14, 32'h0000_9000, OP_LW, 32'h0);
        tick();
        idle();
        stall_hi = 0;
        while (bus_err !== 1'b1 && stall_hi < 40) begin
            tick();
            stall_hi++;
        end
        chk("tmo_cycles", 32'(stall_hi), 32'd16);
        chk("tmo_req", 32'(bus.req), 32'd0);
        chk("tmo_wb_we", 32'(wb_we), 32'd0);
        tick();
        chk("tmo_pulse_end", 32'(bus_err), 32'd0);
`endif

        tick();
        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
